// File: rtl/univ_shift_reg.sv
// Universal shift/rotate/load register with serial-fill counter and one-cycle word-full pulse.
// One-cycle latency on every operation; en=0 stalls the register and counter and suppresses full.
module univ_shift_reg #(
   parameter  int WIDTH = 8,
   localparam int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] pout,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CNTW-1:0]  fill_cnt,
   output logic             full
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_ROR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;

   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

   logic [WIDTH-1:0] r_q, r_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             full_q, full_d;
   logic             serial;

   always_comb begin
      r_d    = r_q;
      cnt_d  = cnt_q;
      full_d = 1'b0;
      serial = 1'b0;
      if (en) begin
         case (mode)
            MODE_HOLD: r_d = r_q;
            MODE_SHR: begin
               r_d    = {sin_r, r_q[WIDTH-1:1]};
               serial = 1'b1;
            end
            MODE_SHL: begin
               r_d    = {r_q[WIDTH-2:0], sin_l};
               serial = 1'b1;
            end
            MODE_ROR:  r_d = {r_q[0], r_q[WIDTH-1:1]};
            MODE_ROL:  r_d = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_LOAD: begin
               r_d   = pin;
               cnt_d = '0;
            end
            MODE_ASR:  r_d = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            default:   r_d = r_q;
         endcase
         // Only serial shifts advance the fill; the WIDTH-th one wraps and fires full.
         if (serial) begin
            if (cnt_q == CNT_LAST) begin
               cnt_d  = '0;
               full_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q    <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         r_q    <= r_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
      end
   end

   assign pout     = r_q;
   assign sout_r   = r_q[0];
   assign sout_l   = r_q[WIDTH-1];
   assign fill_cnt = cnt_q;
   assign full     = full_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboarded bench: WIDTH=4 and WIDTH=8 instances against an arithmetic reference model.
module tb_univ_shift_reg;

   localparam logic [2:0] HOLD = 3'd0, SHR = 3'd1, SHL = 3'd2, ROR = 3'd3,
                          ROL  = 3'd4, LOAD = 3'd5, ASR = 3'd6, RSV = 3'd7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4, en4, sr4, sl4;
   logic [2:0] mode4;
   logic [3:0] pin4, pout4;
   logic       sor4, sol4, full4;
   logic [2:0] cnt4;

   logic       rst8, en8, sr8, sl8;
   logic [2:0] mode8;
   logic [7:0] pin8, pout8;
   logic       sor8, sol8, full8;
   logic [3:0] cnt8;

   univ_shift_reg #(.WIDTH(4)) u4 (
      .clk(clk), .reset(rst4), .en(en4), .mode(mode4), .sin_r(sr4), .sin_l(sl4),
      .pin(pin4), .pout(pout4), .sout_r(sor4), .sout_l(sol4), .fill_cnt(cnt4), .full(full4)
   );

   univ_shift_reg #(.WIDTH(8)) u8 (
      .clk(clk), .reset(rst8), .en(en8), .mode(mode8), .sin_r(sr8), .sin_l(sl8),
      .pin(pin8), .pout(pout8), .sout_r(sor8), .sout_l(sol8), .fill_cnt(cnt8), .full(full8)
   );

   typedef struct {
      int pout;
      int cnt;
      bit full;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];
   int   m_r[2];
   int   m_cnt[2];
   bit   m_full[2];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference: register as an integer, fill count as serial shifts modulo width.
   function automatic void model(input int d, input int w, input bit rst, input bit en,
                                 input logic [2:0] mode, input bit sr, input bit sl, input int pin);
      int mask = (1 << w) - 1;
      int r    = m_r[d];
      bit ser  = 1'b0;
      if (!rst) begin
         m_r[d] = 0; m_cnt[d] = 0; m_full[d] = 1'b0;
         return;
      end
      m_full[d] = 1'b0;
      if (!en) return;
      case (mode)
         SHR:  begin r = (r >> 1) | (int'(sr) << (w - 1)); ser = 1'b1; end
         SHL:  begin r = ((r << 1) | int'(sl)) & mask;     ser = 1'b1; end
         ROR:  r = (r >> 1) | ((r & 1) << (w - 1));
         ROL:  r = ((r << 1) | (r >> (w - 1))) & mask;
         LOAD: begin r = pin & mask; m_cnt[d] = 0; end
         ASR:  r = (r >> 1) | (r & (1 << (w - 1)));
         default: ;
      endcase
      if (ser) begin
         m_cnt[d]  = (m_cnt[d] + 1) % w;
         m_full[d] = (m_cnt[d] == 0);
      end
      m_r[d] = r;
   endfunction

   // Drives one cycle on the selected instance; the other idles with en=0.
   task automatic step(input int d, input bit rst, input bit en, input logic [2:0] mode,
                       input bit sr, input bit sl, input int pin);
      if (d == 0) begin
         rst4 = rst; en4 = en; mode4 = mode; sr4 = sr; sl4 = sl; pin4 = pin[3:0];
         rst8 = 1'b1; en8 = 1'b0; mode8 = SHR; sr8 = ~sr; sl8 = sl; pin8 = 8'hFF;
      end else begin
         rst8 = rst; en8 = en; mode8 = mode; sr8 = sr; sl8 = sl; pin8 = pin[7:0];
         rst4 = 1'b1; en4 = 1'b0; mode4 = SHL; sr4 = sr; sl4 = ~sl; pin4 = 4'hF;
      end
      @(posedge clk);
      if (d == 0) begin
         model(0, 4, rst, en, mode, sr, sl, pin);
         model(1, 8, 1'b1, 1'b0, SHR, ~sr, sl, 255);
      end else begin
         model(1, 8, rst, en, mode, sr, sl, pin);
         model(0, 4, 1'b1, 1'b0, SHL, sr, ~sl, 15);
      end
      q4.push_back('{m_r[0], m_cnt[0], m_full[0]});
      q8.push_back('{m_r[1], m_cnt[1], m_full[1]});
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         chk("sb4_pout",   {28'b0, pout4}, e.pout);
         chk("sb4_cnt",    {29'b0, cnt4},  e.cnt);
         chk("sb4_full",   {31'b0, full4}, {31'b0, e.full});
         chk("sb4_sout_r", {31'b0, sor4},  e.pout & 1);
         chk("sb4_sout_l", {31'b0, sol4},  (e.pout >> 3) & 1);
      end
      if (q8.size() > 0) begin
         e = q8.pop_front();
         chk("sb8_pout",   {24'b0, pout8}, e.pout);
         chk("sb8_cnt",    {28'b0, cnt8},  e.cnt);
         chk("sb8_full",   {31'b0, full8}, {31'b0, e.full});
         chk("sb8_sout_r", {31'b0, sor8},  e.pout & 1);
         chk("sb8_sout_l", {31'b0, sol8},  (e.pout >> 7) & 1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] fill_pout [4];
      int         fill_cnt  [4];
      logic       fill_sin  [4];
      int         bits [32];
      int         npulse, last, word, full_seen;
      logic [7:0] hold_p;
      logic [3:0] hold_c;

      fill_pout = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
      fill_cnt  = '{1, 2, 3, 0};
      fill_sin  = '{1'b1, 1'b0, 1'b1, 1'b1};

      rst4 = 1'b0; en4 = 1'b1; mode4 = LOAD; sr4 = 1'b0; sl4 = 1'b0; pin4 = 4'hF;
      rst8 = 1'b0; en8 = 1'b1; mode8 = LOAD; sr8 = 1'b0; sl8 = 1'b0; pin8 = 8'hFF;
      @(posedge clk);
      m_r = '{0, 0}; m_cnt = '{0, 0}; m_full = '{1'b0, 1'b0};
      @(negedge clk);
      chk("rst_pout4", {28'b0, pout4}, 0);
      chk("rst_cnt8",  {28'b0, cnt8},  0);
      chk("rst_full8", {31'b0, full8}, 0);

      // Serial fill on WIDTH=4
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, SHR, fill_sin[i], 0, 0);
         chk("fill_pout", {28'b0, pout4}, {28'b0, fill_pout[i]});
         chk("fill_cnt",  {29'b0, cnt4},  fill_cnt[i]);
         chk("fill_full", {31'b0, full4}, (i == 3) ? 1 : 0);
      end
      step(0, 1, 1, HOLD, 0, 0, 0);
      chk("fill_full_drop", {31'b0, full4}, 0);
      chk("fill_sout_r",    {31'b0, sor4},  1);

      // Load and rotates on WIDTH=8
      step(1, 1, 1, LOAD, 0, 0, 'hA5);
      chk("load_a5", {24'b0, pout8}, 'hA5);
      chk("load_cnt", {28'b0, cnt8}, 0);
      step(1, 1, 1, ROR, 0, 0, 0);
      chk("ror_d2", {24'b0, pout8}, 'hD2);
      step(1, 1, 1, LOAD, 0, 0, 'hA5);
      step(1, 1, 1, ROL, 0, 0, 0);
      chk("rol_4b", {24'b0, pout8}, 'h4B);
      step(1, 1, 1, LOAD, 0, 0, 'hA5);
      full_seen = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 1, ROR, 0, 0, 0);
         if (full8 !== 1'b0) full_seen++;
      end
      chk("ror8_back", {24'b0, pout8}, 'hA5);
      chk("ror8_nofull", full_seen, 0);

      // ASR and SHL
      step(1, 1, 1, LOAD, 0, 0, 'h96);
      step(1, 1, 1, ASR, 0, 0, 0);
      chk("asr_cb", {24'b0, pout8}, 'hCB);
      step(1, 1, 1, ASR, 0, 0, 0);
      chk("asr_e5", {24'b0, pout8}, 'hE5);
      step(1, 1, 1, LOAD, 0, 0, 'h81);
      step(1, 1, 1, SHL, 0, 1, 0);
      chk("shl_03", {24'b0, pout8}, 'h03);
      chk("shl_cnt", {28'b0, cnt8}, 1);

      // Enable stall and reserved mode mid-fill on WIDTH=4
      step(0, 1, 1, LOAD, 0, 0, 0);
      step(0, 1, 1, SHR, 1, 0, 0);
      step(0, 1, 1, SHR, 0, 0, 0);
      hold_p = {4'b0, pout4};
      hold_c = {1'b0, cnt4};
      for (int i = 0; i < 3; i++) step(0, 1, 0, SHR, i[0], 0, 0);
      step(0, 1, 1, RSV, 1, 1, 'hF);
      chk("stall_pout", {28'b0, pout4}, {24'b0, hold_p});
      chk("stall_cnt",  {29'b0, cnt4},  {28'b0, hold_c});
      step(0, 1, 1, SHR, 1, 0, 0);
      chk("resume_full1", {31'b0, full4}, 0);
      step(0, 1, 1, SHR, 1, 0, 0);
      chk("resume_full2", {31'b0, full4}, 1);

      // Reset mid-fill, then reset versus LOAD
      for (int i = 0; i < 3; i++) step(0, 1, 1, SHR, 1, 0, 0);
      step(0, 0, 1, SHR, 1, 0, 0);
      chk("midrst_pout", {28'b0, pout4}, 0);
      chk("midrst_cnt",  {29'b0, cnt4},  0);
      chk("midrst_full", {31'b0, full4}, 0);
      full_seen = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, SHL, 0, 1, 0);
         if (i < 3 && full4 !== 1'b0) full_seen++;
      end
      chk("midrst_early_full", full_seen, 0);
      chk("midrst_full4", {31'b0, full4}, 1);
      step(0, 0, 1, LOAD, 0, 0, 'hF);
      chk("rst_beats_load", {28'b0, pout4}, 0);

      // Continuous streaming on WIDTH=8
      step(1, 1, 1, LOAD, 0, 0, 0);
      npulse = 0;
      last   = -1;
      for (int k = 0; k < 32; k++) begin
         bits[k] = int'($urandom_range(1, 0));
         step(1, 1, 1, SHR, bits[k][0], 0, 0);
         if (full8 === 1'b1) begin
            npulse++;
            if (last >= 0) chk("stream_gap", k - last, 8);
            last = k;
            word = 0;
            if (k >= 7) for (int i = 0; i < 8; i++) word |= bits[k - 7 + i] << i;
            chk("stream_word", {24'b0, pout8}, word);
         end
      end
      chk("stream_pulses", npulse, 4);

      // Randomised soak on both widths
      for (int i = 0; i < 400; i++) begin
         step(int'($urandom_range(1, 0)), ($urandom_range(31, 0) != 0),
              ($urandom_range(7, 0) != 0), 3'($urandom_range(7, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(255, 0)));
      end

      @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; next generation of the team's fixed-direction SISO shifter.
- Adds selectable direction, rotate, arithmetic shift, parallel load, parallel readout, clock enable and a serial-fill counter with a one-cycle "word full" pulse.
- Used as a serialiser/deserialiser front end and as a general datapath shifter.

Parameters:
- WIDTH, 8, register width in bits; legal values are WIDTH >= 2.
- CNTW, $clog2(WIDTH+1), width of fill_cnt. This is a localparam derived from WIDTH and is not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- en  input  1  clock enable; 0 means the register holds its state
- mode  input  3  operation select (see Behaviour)
- sin_r  input  1  serial input entering at the MSB on right shifts
- sin_l  input  1  serial input entering at the LSB on left shifts
- pin  input  WIDTH  parallel load data
- pout  output  WIDTH  current register contents (r_reg)
- sout_r  output  1  r_reg[0], the bit leaving on right shifts
- sout_l  output  1  r_reg[WIDTH-1], the bit leaving on left shifts
- fill_cnt  output  CNTW  number of serial shifts since the last load, reset or wrap
- full  output  1  registered pulse, high for exactly one cycle when a word completes

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - reset=0 at an edge forces r_reg=0, fill_cnt=0, full=0. Reset has priority over en and mode.
  - Reset asserted mid-fill discards any partial count.
- Output timing:
  - pout, sout_r, sout_l and fill_cnt are direct register outputs with no combinational path from the inputs.
  - Every operation has one-cycle latency: the result is visible after the edge.
- Enable: when en=0, r_reg and fill_cnt hold, and full is 0 on that cycle.
- mode encoding, applied when en=1 and reset=1:
  - 000 HOLD: no change.
  - 001 SHR (shift right): r_next = {sin_r, r_reg[WIDTH-1:1]}.
  - 010 SHL (shift left): r_next = {r_reg[WIDTH-2:0], sin_l}.
  - 011 ROR (rotate right): r_next = {r_reg[0], r_reg[WIDTH-1:1]}.
  - 100 ROL (rotate left): r_next = {r_reg[WIDTH-2:0], r_reg[WIDTH-1]}.
  - 101 LOAD: r_next = pin.
  - 110 ASR (arithmetic shift right): r_next = {r_reg[WIDTH-1], r_reg[WIDTH-1:1]}.
  - 111 reserved: behaves as HOLD. Must not affect fill_cnt or full.
- Fill counter:
  - Only SHR and SHL are serial shifts.
  - On a serial shift with fill_cnt < WIDTH-1: fill_cnt increments and full=0.
  - On a serial shift with fill_cnt == WIDTH-1 (the WIDTH-th bit): fill_cnt wraps to 0 and full=1 for the following cycle only.
  - LOAD sets fill_cnt=0 and full=0.
  - ROR, ROL, ASR, HOLD and reserved leave fill_cnt unchanged and drive full=0.
  - Mixing SHR and SHL within one fill still counts each shift. Direction consistency is the user's responsibility.
- Back-to-back words: continuous serial shifting yields a full pulse every WIDTH enabled shift cycles with no dead cycle. Disabled cycles (en=0) stretch the interval but never drop or duplicate a count.
- Output relationships: sout_r and sout_l always track pout[0] and pout[WIDTH-1], including directly after reset and after LOAD.
- The register must never hold X once reset has been applied. Inputs are sampled only when en=1.

Test Plan:
- Reset/serial fill, WIDTH=4:
  - Stimulus: reset=0 for 1 edge, then SHR with sin_r = 1, 0, 1, 1 on consecutive edges.
  - Required: pout sequence 1000, 0100, 1010, 1101; fill_cnt 1, 2, 3, 0.
  - Required: full=1 only in the cycle after the 4th shift; sout_r=1 at the end.
- Load and rotates, WIDTH=8:
  - LOAD pin=8'hA5 gives pout=A5 and fill_cnt=0.
  - ROR from A5 gives D2.
  - Reload A5, then ROL gives 4B.
  - Eight consecutive RORs from A5 return to A5, with full never asserted.
- ASR and SHL, WIDTH=8:
  - LOAD 8'h96, then ASR gives CB, and ASR again gives E5.
  - LOAD 8'h81, then SHL with sin_l=1 gives 03, with fill_cnt=1.
- Enable and reserved mode:
  - Mid-fill (fill_cnt=2) drive en=0 for 3 cycles with toggling sin_r: pout and fill_cnt are unchanged and full=0.
  - Then mode=111 with en=1: no change.
  - Then resume shifting: full fires after exactly 2 more SHR.
- Reset mid-operation, WIDTH=4:
  - After 3 SHR, assert reset for 1 edge: pout=0, fill_cnt=0, full=0.
  - Full then requires 4 further shifts.
  - Reset together with mode=LOAD: reset wins and pout=0.
- Continuous streaming, WIDTH=8:
  - Run 32 consecutive SHR cycles with a random sin_r.
  - Required: full pulses exactly 4 times, 8 cycles apart.
  - Required: each pout word sampled at a full pulse equals the last 8 sin_r bits, with the first-shifted bit at the LSB.
